// File: rtl/cache_refill_ctrl.sv
// Refill controller for a set-associative data cache. It writes back a dirty victim word
// if needed, fetches or allocates the missing word, then returns a single-cycle fill.
module cache_refill_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned WAY            = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   miss_valid,
    output logic                                   miss_ready,
    input  logic [31:0]                            miss_addr,
    input  logic                                   miss_write,
    input  logic [31:0]                            miss_wdata,
    input  logic [((WAY > 1) ? $clog2(WAY) : 1)-1:0] miss_way,
    input  logic                                   victim_dirty,
    input  logic [31:0]                            victim_addr,
    input  logic [31:0]                            victim_data,
    output logic                                   mem_req_valid,
    input  logic                                   mem_req_ready,
    output logic                                   mem_req_write,
    output logic [31:0]                            mem_req_addr,
    output logic [31:0]                            mem_req_wdata,
    input  logic                                   mem_resp_valid,
    input  logic [31:0]                            mem_resp_data,
    output logic                                   fill_valid,
    output logic [31:0]                            fill_addr,
    output logic [((WAY > 1) ? $clog2(WAY) : 1)-1:0] fill_way,
    output logic [31:0]                            fill_data,
    output logic                                   fill_dirty,
    output logic                                   miss_err,
    output logic                                   err_sticky,
    output logic                                   busy
);
    localparam int unsigned   WW       = (WAY > 1) ? $clog2(WAY) : 1;
    localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_REQ,
        S_RD_REQ,
        S_RD_WAIT,
        S_FILL
    } state_t;

    state_t        r_state;
    logic [31:0]   r_miss_addr;
    logic          r_miss_write;
    logic [31:0]   r_miss_wdata;
    logic [WW-1:0] r_miss_way;
    logic [CW-1:0] r_cnt;

    logic [31:0]   w_miss_addr_al;
    logic [31:0]   w_victim_addr_al;

    assign w_miss_addr_al   = miss_addr & 32'hFFFF_FFFC;
    assign w_victim_addr_al = victim_addr & 32'hFFFF_FFFC;

    assign miss_ready = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);

    // NOTE: every register, outputs included, sits on the asynchronous reset and is
    // updated with non-blocking assignments only, so a reset drops a request mid-cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_miss_addr   <= '0;
            r_miss_write  <= 1'b0;
            r_miss_wdata  <= '0;
            r_miss_way    <= '0;
            r_cnt         <= '0;
            mem_req_valid <= 1'b0;
            mem_req_write <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            fill_valid    <= 1'b0;
            fill_addr     <= '0;
            fill_way      <= '0;
            fill_data     <= '0;
            fill_dirty    <= 1'b0;
            miss_err      <= 1'b0;
            err_sticky    <= 1'b0;
        end else begin
            fill_valid <= 1'b0;
            miss_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (miss_valid) begin
                        r_miss_addr  <= w_miss_addr_al;
                        r_miss_write <= miss_write;
                        r_miss_wdata <= miss_wdata;
                        r_miss_way   <= miss_way;
                        if (victim_dirty) begin
                            r_state       <= S_WB_REQ;
                            mem_req_valid <= 1'b1;
                            mem_req_write <= 1'b1;
                            mem_req_addr  <= w_victim_addr_al;
                            mem_req_wdata <= victim_data;
                        end else if (!miss_write) begin
                            r_state       <= S_RD_REQ;
                            mem_req_valid <= 1'b1;
                            mem_req_write <= 1'b0;
                            mem_req_addr  <= w_miss_addr_al;
                            mem_req_wdata <= '0;
                        end else begin
                            // Clean store miss: allocate the store data without touching memory.
                            r_state    <= S_FILL;
                            fill_valid <= 1'b1;
                            fill_addr  <= w_miss_addr_al;
                            fill_way   <= miss_way;
                            fill_data  <= miss_wdata;
                            fill_dirty <= 1'b1;
                        end
                    end
                end
                S_WB_REQ: begin
                    if (mem_req_ready) begin
                        if (!r_miss_write) begin
                            r_state       <= S_RD_REQ;
                            mem_req_valid <= 1'b1;
                            mem_req_write <= 1'b0;
                            mem_req_addr  <= r_miss_addr;
                            mem_req_wdata <= '0;
                        end else begin
                            r_state       <= S_FILL;
                            mem_req_valid <= 1'b0;
                            fill_valid    <= 1'b1;
                            fill_addr     <= r_miss_addr;
                            fill_way      <= r_miss_way;
                            fill_data     <= r_miss_wdata;
                            fill_dirty    <= 1'b1;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (mem_req_ready) begin
                        r_state       <= S_RD_WAIT;
                        mem_req_valid <= 1'b0;
                        r_cnt         <= '0;
                    end
                end
                S_RD_WAIT: begin
                    // A response in the last allowed cycle still wins over the timeout.
                    if (mem_resp_valid) begin
                        r_state    <= S_FILL;
                        fill_valid <= 1'b1;
                        fill_addr  <= r_miss_addr;
                        fill_way   <= r_miss_way;
                        fill_data  <= mem_resp_data;
                        fill_dirty <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state    <= S_IDLE;
                        miss_err   <= 1'b1;
                        err_sticky <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_FILL: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: memory requests and fills are matched in order
// against expectations queued by each scenario, plus per-scenario cycle-timing checks.
module tb_cache_refill_ctrl;
    localparam int TO = 4;
    localparam logic [137:0] RST_VEC = 138'd1;

    logic        clk;
    logic        reset;
    logic        miss_valid;
    logic        miss_ready;
    logic [31:0] miss_addr;
    logic        miss_write;
    logic [31:0] miss_wdata;
    logic [1:0]  miss_way;
    logic        victim_dirty;
    logic [31:0] victim_addr;
    logic [31:0] victim_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_write;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        fill_valid;
    logic [31:0] fill_addr;
    logic [1:0]  fill_way;
    logic [31:0] fill_data;
    logic        fill_dirty;
    logic        miss_err;
    logic        err_sticky;
    logic        busy;

    cache_refill_ctrl #(.TIMEOUT_CYCLES(TO), .WAY(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .miss_valid     (miss_valid),
        .miss_ready     (miss_ready),
        .miss_addr      (miss_addr),
        .miss_write     (miss_write),
        .miss_wdata     (miss_wdata),
        .miss_way       (miss_way),
        .victim_dirty   (victim_dirty),
        .victim_addr    (victim_addr),
        .victim_data    (victim_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .fill_valid     (fill_valid),
        .fill_addr      (fill_addr),
        .fill_way       (fill_way),
        .fill_data      (fill_data),
        .fill_dirty     (fill_dirty),
        .miss_err       (miss_err),
        .err_sticky     (err_sticky),
        .busy           (busy)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  way;
        logic [31:0] data;
        logic        dirty;
    } fill_t;

    req_t  exp_req_q[$];
    fill_t exp_fill_q[$];
    int    checks = 0;
    int    errors = 0;
    int    fill_cyc, err_cyc, idle_cyc, req_cycles, fill_cnt, err_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #20000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic logic [137:0] out_vec();
        return {mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
                fill_valid, fill_addr, fill_way, fill_data, fill_dirty,
                miss_err, err_sticky, busy, miss_ready};
    endfunction

    // Scoreboard monitor: compares every accepted request and every fill with the queue heads.
    initial begin
        logic prev_valid;
        req_t prev_req, cur, e;
        fill_t fcur, fe;
        prev_valid = 1'b0;
        prev_req   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 1'b0;
            end else begin
                cur = '{mem_req_write, mem_req_addr, mem_req_wdata};
                if (prev_valid) begin
                    checks++;
                    if (mem_req_valid !== 1'b1 || cur !== prev_req) begin
                        errors++;
                        $display("FAIL req_stable got valid=%0b %h want valid=1 %h", mem_req_valid, cur, prev_req);
                    end
                end
                if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
                    checks++;
                    if (exp_req_q.size() == 0) begin
                        errors++;
                        $display("FAIL mem_req got unexpected wr=%0b addr=%h want none", cur.wr, cur.addr);
                    end else begin
                        e = exp_req_q.pop_front();
                        if (cur.wr !== e.wr || cur.addr !== e.addr || (e.wr && cur.data !== e.data)) begin
                            errors++;
                            $display("FAIL mem_req got wr=%0b addr=%h data=%h want wr=%0b addr=%h data=%h",
                                     cur.wr, cur.addr, cur.data, e.wr, e.addr, e.data);
                        end
                    end
                    prev_valid = 1'b0;
                end else if (mem_req_valid === 1'b1) begin
                    prev_valid = 1'b1;
                    prev_req   = cur;
                end else begin
                    prev_valid = 1'b0;
                end
                if (fill_valid === 1'b1) begin
                    fcur = '{fill_addr, fill_way, fill_data, fill_dirty};
                    checks++;
                    if (exp_fill_q.size() == 0) begin
                        errors++;
                        $display("FAIL fill got unexpected addr=%h data=%h want none", fill_addr, fill_data);
                    end else begin
                        fe = exp_fill_q.pop_front();
                        if (fcur !== fe) begin
                            errors++;
                            $display("FAIL fill got addr=%h way=%0d data=%h dirty=%0b want addr=%h way=%0d data=%h dirty=%0b",
                                     fcur.addr, fcur.way, fcur.data, fcur.dirty, fe.addr, fe.way, fe.data, fe.dirty);
                        end
                    end
                end
            end
        end
    end

    // Presents one miss from posedge+1 and returns just after the accepting edge,
    // with the miss inputs scrambled so later changes must be ignored.
    task automatic accept_miss(input logic [31:0] a, input logic w, input logic [31:0] wd,
                               input logic [1:0] way, input logic vd, input logic [31:0] va,
                               input logic [31:0] vdat);
        miss_valid   = 1'b1;
        miss_addr    = a;
        miss_write   = w;
        miss_wdata   = wd;
        miss_way     = way;
        victim_dirty = vd;
        victim_addr  = va;
        victim_data  = vdat;
        @(negedge clk);
        checks++;
        if (miss_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready got %0b want 1", miss_ready);
        end
        @(posedge clk);
        #1;
        miss_valid   = 1'b0;
        miss_addr    = $urandom;
        miss_write   = 1'($urandom_range(0, 1));
        miss_wdata   = $urandom;
        miss_way     = 2'($urandom_range(0, 3));
        victim_dirty = 1'($urandom_range(0, 1));
        victim_addr  = $urandom;
        victim_data  = $urandom;
    endtask

    // Plays memory for max_cyc cycles after acceptance: ready from cycle rdy_from on,
    // and a response resp_delay cycles after the read handshake (0 = never).
    task automatic run_txn(input int max_cyc, input int rdy_from, input int resp_delay,
                           input logic [31:0] rdata);
        int rd_hs_cyc;
        rd_hs_cyc  = -1;
        fill_cyc   = 0;
        err_cyc    = 0;
        idle_cyc   = 0;
        req_cycles = 0;
        fill_cnt   = 0;
        err_cnt    = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (mem_req_valid === 1'b1) req_cycles++;
            if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1 && mem_req_write === 1'b0) rd_hs_cyc = i;
            if (fill_valid === 1'b1) begin
                fill_cnt++;
                if (fill_cyc == 0) fill_cyc = i;
            end
            if (miss_err === 1'b1) begin
                err_cnt++;
                if (err_cyc == 0) err_cyc = i;
            end
            if (miss_ready === 1'b1 && idle_cyc == 0) idle_cyc = i;
            @(posedge clk);
            #1;
            mem_req_ready  = (i + 1 >= rdy_from);
            mem_resp_valid = (resp_delay > 0 && rd_hs_cyc > 0 && i + 1 == rd_hs_cyc + resp_delay);
            mem_resp_data  = mem_resp_valid ? rdata : $urandom;
        end
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_vec() !== RST_VEC) begin
            errors++;
            $display("FAIL reset_values got %h want %h", out_vec(), RST_VEC);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (out_vec() !== RST_VEC) begin
            errors++;
            $display("FAIL post_reset_idle got %h want %h", out_vec(), RST_VEC);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_clean_load();
        exp_req_q.push_back(req_t'{1'b0, 32'h0000_1234, 32'h0});
        exp_fill_q.push_back(fill_t'{32'h0000_1234, 2'd2, 32'hDEAD_BEEF, 1'b0});
        mem_req_ready = 1'b1;
        accept_miss(32'h0000_1236, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 32'h0);
        run_txn(8, 1, 1, 32'hDEAD_BEEF);
        checks++;
        if (fill_cyc != 3 || fill_cnt != 1) begin
            errors++;
            $display("FAIL load_fill_timing got cyc=%0d cnt=%0d want cyc=3 cnt=1", fill_cyc, fill_cnt);
        end
        checks++;
        if (idle_cyc != 4 || req_cycles != 1 || err_cnt != 0) begin
            errors++;
            $display("FAIL load_handshake got idle=%0d reqcyc=%0d err=%0d want 4 1 0", idle_cyc, req_cycles, err_cnt);
        end
    endtask

    task automatic test_clean_store();
        exp_fill_q.push_back(fill_t'{32'h0000_2000, 2'd3, 32'h5A5A_0F0F, 1'b1});
        mem_req_ready = 1'b1;
        accept_miss(32'h0000_2003, 1'b1, 32'h5A5A_0F0F, 2'd3, 1'b0, 32'h0000_9990, 32'h1);
        run_txn(4, 1, 0, 32'h0);
        checks++;
        if (fill_cyc != 1 || fill_cnt != 1 || idle_cyc != 2 || req_cycles != 0) begin
            errors++;
            $display("FAIL store_timing got fill=%0d cnt=%0d idle=%0d reqcyc=%0d want 1 1 2 0",
                     fill_cyc, fill_cnt, idle_cyc, req_cycles);
        end
    endtask

    task automatic test_dirty_store_stall();
        exp_req_q.push_back(req_t'{1'b1, 32'h0000_0080, 32'hAAAA_5555});
        exp_fill_q.push_back(fill_t'{32'h0000_0040, 2'd1, 32'h1111_2222, 1'b1});
        mem_req_ready = 1'b0;
        accept_miss(32'h0000_0040, 1'b1, 32'h1111_2222, 2'd1, 1'b1, 32'h0000_0080, 32'hAAAA_5555);
        run_txn(10, 4, 0, 32'h0);
        checks++;
        if (req_cycles != 4) begin
            errors++;
            $display("FAIL wb_held_cycles got %0d want 4", req_cycles);
        end
        checks++;
        if (fill_cyc != 5 || fill_cnt != 1 || idle_cyc != 6) begin
            errors++;
            $display("FAIL dirty_store_fill got cyc=%0d cnt=%0d idle=%0d want 5 1 6", fill_cyc, fill_cnt, idle_cyc);
        end
    endtask

    task automatic test_dirty_load();
        exp_req_q.push_back(req_t'{1'b1, 32'h0000_0080, 32'h0BAD_F00D});
        exp_req_q.push_back(req_t'{1'b0, 32'h0000_0040, 32'h0});
        exp_fill_q.push_back(fill_t'{32'h0000_0040, 2'd0, 32'hCAFE_1234, 1'b0});
        mem_req_ready = 1'b1;
        accept_miss(32'h0000_0040, 1'b0, 32'h0, 2'd0, 1'b1, 32'h0000_0082, 32'h0BAD_F00D);
        run_txn(10, 1, 1, 32'hCAFE_1234);
        checks++;
        if (fill_cyc != 4 || fill_cnt != 1 || req_cycles != 2 || idle_cyc != 5) begin
            errors++;
            $display("FAIL dirty_load_timing got fill=%0d cnt=%0d reqcyc=%0d idle=%0d want 4 1 2 5",
                     fill_cyc, fill_cnt, req_cycles, idle_cyc);
        end
    endtask

    task automatic test_resp_on_timeout();
        exp_req_q.push_back(req_t'{1'b0, 32'h0000_3000, 32'h0});
        exp_fill_q.push_back(fill_t'{32'h0000_3000, 2'd1, 32'h7777_8888, 1'b0});
        mem_req_ready = 1'b1;
        accept_miss(32'h0000_3001, 1'b0, 32'h0, 2'd1, 1'b0, 32'h0, 32'h0);
        run_txn(10, 1, TO, 32'h7777_8888);
        checks++;
        if (fill_cyc != TO + 2 || fill_cnt != 1 || err_cnt != 0 || err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL resp_wins got fill=%0d cnt=%0d err=%0d sticky=%0b want %0d 1 0 0",
                     fill_cyc, fill_cnt, err_cnt, err_sticky, TO + 2);
        end
    endtask

    task automatic test_timeout();
        int late_fills;
        int late_busy;
        exp_req_q.push_back(req_t'{1'b0, 32'h0000_5000, 32'h0});
        mem_req_ready = 1'b1;
        accept_miss(32'h0000_5000, 1'b0, 32'h0, 2'd3, 1'b0, 32'h0, 32'h0);
        run_txn(8, 1, 0, 32'h0);
        checks++;
        if (err_cyc != TO + 2 || err_cnt != 1) begin
            errors++;
            $display("FAIL timeout_pulse got cyc=%0d cnt=%0d want %0d 1", err_cyc, err_cnt, TO + 2);
        end
        checks++;
        if (fill_cnt != 0 || idle_cyc != TO + 2 || err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL timeout_state got fills=%0d idle=%0d sticky=%0b want 0 %0d 1",
                     fill_cnt, idle_cyc, err_sticky, TO + 2);
        end
        late_fills = 0;
        late_busy  = 0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0BAD_0BAD;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (fill_valid === 1'b1) late_fills++;
            if (busy !== 1'b0) late_busy++;
            @(posedge clk);
            #1;
            mem_resp_valid = 1'b0;
        end
        checks++;
        if (late_fills != 0 || late_busy != 0) begin
            errors++;
            $display("FAIL late_resp_ignored got fills=%0d busy=%0d want 0 0", late_fills, late_busy);
        end
        exp_req_q.push_back(req_t'{1'b0, 32'h0000_5100, 32'h0});
        exp_fill_q.push_back(fill_t'{32'h0000_5100, 2'd2, 32'h1357_9BDF, 1'b0});
        accept_miss(32'h0000_5102, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 32'h0);
        run_txn(8, 1, 2, 32'h1357_9BDF);
        checks++;
        if (fill_cyc != 4 || fill_cnt != 1 || err_cnt != 0 || err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL after_timeout got fill=%0d cnt=%0d err=%0d sticky=%0b want 4 1 0 1",
                     fill_cyc, fill_cnt, err_cnt, err_sticky);
        end
    endtask

    task automatic test_reset_mid();
        int post_fills;
        int post_busy;
        exp_req_q.push_back(req_t'{1'b0, 32'h0000_6000, 32'h0});
        mem_req_ready = 1'b1;
        accept_miss(32'h0000_6000, 1'b0, 32'h0, 2'd1, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state got busy=%0b sticky=%0b want 1 1", busy, err_sticky);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_vec() !== RST_VEC) begin
            errors++;
            $display("FAIL reset_in_rd_wait got %h want %h", out_vec(), RST_VEC);
        end
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hFEED_0001;
        post_fills = 0;
        post_busy  = 0;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            #1;
            mem_resp_valid = 1'b0;
            @(negedge clk);
            if (fill_valid === 1'b1) post_fills++;
            if (busy !== 1'b0) post_busy++;
        end
        checks++;
        if (post_fills != 0 || post_busy != 0) begin
            errors++;
            $display("FAIL reset_drops_txn got fills=%0d busy=%0d want 0 0", post_fills, post_busy);
        end
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        accept_miss(32'h0000_7000, 1'b1, 32'h2222_3333, 2'd0, 1'b1, 32'h0000_9000, 32'h4444_5555);
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b1) begin
            errors++;
            $display("FAIL wb_stalled got valid=%0b write=%0b want 1 1", mem_req_valid, mem_req_write);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_vec() !== RST_VEC) begin
            errors++;
            $display("FAIL reset_in_wb_req got %h want %h", out_vec(), RST_VEC);
        end
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        miss_valid     = 1'b0;
        miss_addr      = '0;
        miss_write     = 1'b0;
        miss_wdata     = '0;
        miss_way       = '0;
        victim_dirty   = 1'b0;
        victim_addr    = '0;
        victim_data    = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        test_reset();
        test_clean_load();
        test_clean_store();
        test_dirty_store_stall();
        test_dirty_load();
        test_resp_on_timeout();
        test_timeout();
        test_reset_mid();
        checks++;
        if (exp_req_q.size() != 0 || exp_fill_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got req=%0d fill=%0d pending want 0 0",
                     exp_req_q.size(), exp_fill_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss handler sitting directly downstream of the 4-way set-associative data cache: accepts one miss at a time, writes back a dirty victim word to backing memory, fetches the missing word (read miss) or allocates the store data directly (write miss), then returns a one-cycle fill to the cache. It owns the memory-side valid/ready request channel and enforces a response timeout so a dead memory cannot hang the cache.

## Interface
- TIMEOUT_CYCLES, 255: cycles in RD_WAIT without a response before the read is abandoned (legal range 1..1023).
- WAY, 4: cache associativity; fill_way width is $clog2(WAY).
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; all state and outputs cleared immediately.
- miss_valid  in  1  cache presents a miss.
- miss_ready  out  1  high only in IDLE; transfer on miss_valid && miss_ready at a rising edge.
- miss_addr  in  32  missing word address; bits [1:0] ignored.
- miss_write  in  1  1 = store miss, 0 = load miss.
- miss_wdata  in  32  store data (write miss only).
- miss_way  in  2  victim way chosen by the cache.
- victim_dirty  in  1  victim holds modified data.
- victim_addr  in  32  victim word address.
- victim_data  in  32  victim word.
- mem_req_valid  out  1  memory request pending.
- mem_req_ready  in  1  memory accepts request.
- mem_req_write  out  1  1 = write-back, 0 = read.
- mem_req_addr  out  32  word-aligned address ([1:0] = 0).
- mem_req_wdata  out  32  write-back data.
- mem_resp_valid  in  1  read data valid (single-cycle pulse).
- mem_resp_data  in  32  read data.
- fill_valid  out  1  one-cycle fill pulse to cache.
- fill_addr  out  32  word-aligned fill address.
- fill_way  out  2  way to write.
- fill_data  out  32  fill word.
- fill_dirty  out  1  1 for write-miss fill, 0 for read fill.
- miss_err  out  1  one-cycle pulse on timeout.
- err_sticky  out  1  set on any timeout, cleared only by reset.
- busy  out  1  not in IDLE.

## Operation
- All miss inputs captured into registers at acceptance; later changes on them are ignored until next IDLE.
- States: IDLE, WB_REQ, RD_REQ, RD_WAIT, FILL.
- IDLE: on accept -> WB_REQ if victim_dirty, else RD_REQ if !miss_write, else FILL.
- WB_REQ: mem_req_valid=1, write=1, addr=victim_addr&~3, wdata=victim_data; held stable until mem_req_ready sampled high; writes are posted (no response). Then -> RD_REQ (load) or FILL (store).
- RD_REQ: mem_req_valid=1, write=0, addr=miss_addr&~3, held until mem_req_ready; -> RD_WAIT, timeout counter cleared.
- RD_WAIT: mem_resp_valid captures mem_resp_data -> FILL. Counter increments each cycle without response; when counter reaches TIMEOUT_CYCLES -> IDLE with miss_err pulse and err_sticky set, no fill issued.
- FILL: fill_valid=1 for exactly one cycle, fill_addr=miss_addr&~3, fill_way=captured way, fill_data = response (load) or miss_wdata (store), fill_dirty=miss_write; -> IDLE.
- mem_resp_valid outside RD_WAIT (including late responses after timeout) ignored.
- Response and timeout in the same cycle: response wins, no error.
- mem_req_valid never deasserts before acceptance except on reset.

## Timing
- All outputs registered except miss_ready and busy (decoded from state register).
- Reset values: miss_ready=1, busy=0, every other output 0, state IDLE, counter 0.
- Accept at edge N. Clean store miss: fill_valid during N+1, miss_ready high at N+2.
- Clean load miss, mem_req_ready=1 in N+1, response in N+2: fill_valid in N+3, miss_ready at N+4.
- Dirty victim adds one cycle per WB_REQ cycle (minimum 1).
- Timeout: miss_err asserted in the cycle after the TIMEOUT_CYCLES-th silent RD_WAIT cycle.
- Reset mid-operation: transaction dropped, no fill, mem_req_valid drops asynchronously.

## Test plan
- Clean load miss addr 0x0000_1236, way 2, mem ready immediately, response 0xDEAD_BEEF one cycle later -> one read request addr 0x0000_1234, fill_valid at N+3 with data 0xDEAD_BEEF, way 2, fill_dirty 0.
- Dirty store miss addr 0x40, wdata 0x1111_2222, victim 0x80/0xAAAA_5555, mem_req_ready stalled 3 cycles -> write request held stable 4 cycles, no read request, fill data 0x1111_2222, fill_dirty 1.
- Dirty load miss -> write-back 0x80 then read 0x40 in that order, exactly one fill.
- TIMEOUT_CYCLES=4, no response -> miss_err one-cycle pulse, err_sticky=1, no fill_valid; late response afterward ignored; next miss served normally with err_sticky still 1.
- Response arriving on the timeout cycle -> normal fill, miss_err stays 0.
- Reset asserted during RD_WAIT -> all outputs to reset values at once, miss_ready=1, err_sticky=0, no fill.
